cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 25 ++
 rtl/cache_refill_buf.sv | 56 +++++
 rtl/cache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, line geometry and FSM state encoding for the read-only cache controller.
package cache_ctrl_pkg;

  localparam int DEF_TAG_W  = 20;
  localparam int DEF_IDX_W  = 8;
  localparam int DEF_OFF_W  = 4;
  localparam int DEF_WORD_W = 32;
  localparam int CNT_W      = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_REFILL  = 3'd3,
    ST_FILL    = 3'd4,
    ST_RESPOND = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cache_refill_buf.sv
// Refill line buffer: one word written per accepted beat at the running beat count,
// whole line presented in parallel for the cache write and the critical-word return.
module cache_refill_buf
  import cache_ctrl_pkg::*;
#(
  parameter int OFF_W  = DEF_OFF_W,
  parameter int WORD_W = DEF_WORD_W,
  localparam int WORDS = 1 << OFF_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    wr_i,
  input  logic [WORD_W-1:0]       wdata_i,
  output logic                    last_beat_o,
  output logic [WORDS*WORD_W-1:0] line_o
);

  logic [WORD_W-1:0] mem_q [WORDS];
  logic [OFF_W-1:0]  beat_cnt_q;
  logic [OFF_W-1:0]  beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr_i) begin
      beat_cnt_d = '0;
    end else if (wr_i) begin
      beat_cnt_d = beat_cnt_q + OFF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Data storage carries no reset; only the beat pointer defines what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[beat_cnt_q] <= wdata_i;
    end
  end

  assign last_beat_o = wr_i && (beat_cnt_q == OFF_W'(WORDS - 1));

  always_comb begin
    line_o = '0;
    for (int w = 0; w < WORDS; w++) begin
      line_o[w*WORD_W +: WORD_W] = mem_q[w];
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Blocking read cache controller: hit returns data two edges after accept, miss refills a
// full line from memory, writes it to the cache, then returns the requested word.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int OFF_W  = DEF_OFF_W,
  parameter int WORD_W = DEF_WORD_W,
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W,
  localparam int LINE_W = WORD_W << OFF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic                    cpu_ready,
  output logic                    cpu_rvalid,
  output logic [WORD_W-1:0]       cpu_rdata,
  output logic                    c_mode,
  output logic [IDX_W-1:0]        c_index,
  output logic [OFF_W-1:0]        c_blkoff,
  output logic [TAG_W-1:0]        c_tagin,
  output logic [LINE_W-1:0]       c_datain,
  input  logic [WORD_W-1:0]       c_dataout,
  input  logic [TAG_W-1:0]        c_tagout,
  input  logic                    c_valid,
  output logic                    mem_req,
  output logic [TAG_W+IDX_W-1:0]  mem_addr,
  input  logic                    mem_rvalid,
  input  logic [WORD_W-1:0]       mem_rdata,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cpu_ready_q;
  logic                cpu_rvalid_q;
  logic [WORD_W-1:0]   cpu_rdata_q;
  logic                mem_req_q;
  logic                c_mode_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_d;

  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    idx;
  logic [OFF_W-1:0]    off;
  logic                hit;
  logic                beat_wr;
  logic                last_beat;
  logic [LINE_W-1:0]   line;
  logic [WORD_W-1:0]   rd_word;

  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign off = addr_q[OFF_W-1:0];

  // An unknown valid bit makes this condition non-true, so the FSM takes the miss branch.
  assign hit = (c_valid == 1'b1) && (c_tagout == tag);

  assign beat_wr = (state_q == ST_REFILL) && mem_rvalid;
  assign rd_word = line[off*WORD_W +: WORD_W];

  assign hit_cnt_d  = sat_inc(hit_cnt_q);
  assign miss_cnt_d = sat_inc(miss_cnt_q);

  cache_refill_buf #(
    .OFF_W  (OFF_W),
    .WORD_W (WORD_W)
  ) u_refill_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (state_q == ST_COMPARE),
    .wr_i        (beat_wr),
    .wdata_i     (mem_rdata),
    .last_beat_o (last_beat),
    .line_o      (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cpu_ready_q  <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      c_mode_q     <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q      <= cpu_addr;
            cpu_ready_q <= 1'b0;
            state_q     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          state_q <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (hit) begin
            cpu_rdata_q  <= c_dataout;
            cpu_rvalid_q <= 1'b1;
            hit_cnt_q    <= hit_cnt_d;
            cpu_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            miss_cnt_q <= miss_cnt_d;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (last_beat) begin
            mem_req_q <= 1'b0;
            c_mode_q  <= 1'b1;
            state_q   <= ST_FILL;
          end
        end
        ST_FILL: begin
          c_mode_q <= 1'b0;
          state_q  <= ST_RESPOND;
        end
        ST_RESPOND: begin
          cpu_rdata_q  <= rd_word;
          cpu_rvalid_q <= 1'b1;
          cpu_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          mem_req_q   <= 1'b0;
          c_mode_q    <= 1'b0;
          cpu_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = {tag, idx};
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // The cache commits on the edge that ends FILL; a reset on that edge must suppress it.
  assign c_mode   = c_mode_q & ~rst;
  assign c_index  = idx;
  assign c_blkoff = off;
  assign c_tagin  = tag;
  assign c_datain = line;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a registered-read cache RAM model and a beat-driving memory.
module tb_cache_ctrl;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_ready;
  logic         cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         c_mode;
  logic [7:0]   c_index;
  logic [3:0]   c_blkoff;
  logic [19:0]  c_tagin;
  logic [511:0] c_datain;
  logic [31:0]  c_dataout;
  logic [19:0]  c_tagout;
  logic         c_valid;
  logic         mem_req;
  logic [27:0]  mem_addr;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .c_mode     (c_mode),
    .c_index    (c_index),
    .c_blkoff   (c_blkoff),
    .c_tagin    (c_tagin),
    .c_datain   (c_datain),
    .c_dataout  (c_dataout),
    .c_tagout   (c_tagout),
    .c_valid    (c_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache RAM: reads registered one cycle, whole-line write when c_mode is high.
  logic [31:0]  cmem [256][16];
  logic [19:0]  ctag [256];
  logic [255:0] cval = '0;

  always @(posedge clk) begin
    c_dataout <= cmem[c_index][c_blkoff];
    c_tagout  <= ctag[c_index];
    c_valid   <= cval[c_index];
    if (c_mode) begin
      ctag[c_index] <= c_tagin;
      cval[c_index] <= 1'b1;
      for (int w = 0; w < 16; w++) cmem[c_index][w] <= c_datain[w*32 +: 32];
    end
  end

  int           fill_cnt = 0;
  int           rv_cnt = 0;
  logic [7:0]   fill_idx;
  logic [19:0]  fill_tag;
  logic [511:0] fill_line;

  always @(negedge clk) begin
    if (c_mode) begin
      fill_cnt++;
      fill_idx  = c_index;
      fill_tag  = c_tagin;
      fill_line = c_datain;
    end
    if (cpu_rvalid) rv_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int          lat_obs;
  logic [31:0] rdata_obs;
  logic [27:0] maddr_obs;

  // Issue one read and service the refill; gap inserts an idle beat slot after every beat,
  // abort_beat >= 0 pulses reset instead of delivering that beat.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] base, input bit gap,
                         input int abort_beat, input bit spur);
    int beat;
    bit tog;
    bit got;
    bit first;
    beat = 0; tog = 1'b0; got = 1'b0; first = 1'b1;
    lat_obs = 0; rdata_obs = '0; maddr_obs = '0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int c = 1; c <= 80 && !got; c++) begin
      mem_rvalid = 1'b0;
      if (cpu_rvalid) begin
        got       = 1'b1;
        lat_obs   = c;
        rdata_obs = cpu_rdata;
      end else begin
        if (mem_req) begin
          if (first) begin
            maddr_obs = mem_addr;
            first     = 1'b0;
          end
          if (beat == abort_beat) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
          end
          if (!(gap && tog)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + beat;
            beat++;
          end
          tog = !tog;
        end else if (spur) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
      end
    end
    mem_rvalid = 1'b0;
    check("rvalid_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int f0;
  int r0;
  int acc;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_c_mode", {31'd0, c_mode}, 32'd0);
    check("rst_hit", {16'd0, hit_cnt}, 32'd0);
    check("rst_miss", {16'd0, miss_cnt}, 32'd0);

    // Cold miss then hit on the same line
    do_read(32'h0000_1234, 32'hA000_0000, 1'b0, -1, 1'b0);
    check("m1_maddr", {4'd0, maddr_obs}, 32'h0000_0123);
    check("m1_lat", lat_obs, 32'd21);
    check("m1_rdata", rdata_obs, 32'hA000_0004);
    check("m1_fills", fill_cnt, 32'd1);
    check("m1_fill_idx", {24'd0, fill_idx}, 32'h23);
    check("m1_fill_tag", {12'd0, fill_tag}, 32'h1);
    check("m1_word0", fill_line[31:0], 32'hA000_0000);
    check("m1_word15", fill_line[511:480], 32'hA000_000F);
    check("m1_miss", {16'd0, miss_cnt}, 32'd1);
    check("m1_hit", {16'd0, hit_cnt}, 32'd0);

    do_read(32'h0000_1234, 32'h0, 1'b0, -1, 1'b1);
    check("h1_lat", lat_obs, 32'd3);
    check("h1_rdata", rdata_obs, 32'hA000_0004);
    check("h1_hit", {16'd0, hit_cnt}, 32'd1);
    check("h1_fills", fill_cnt, 32'd1);

    // Tag conflict on index 0x23
    do_read(32'h0000_1230, 32'h0, 1'b0, -1, 1'b0);
    check("h2_lat", lat_obs, 32'd3);
    check("h2_rdata", rdata_obs, 32'hA000_0000);
    check("h2_hit", {16'd0, hit_cnt}, 32'd2);
    do_read(32'h0000_2230, 32'hB000_0000, 1'b0, -1, 1'b0);
    check("cf_maddr", {4'd0, maddr_obs}, 32'h0000_0223);
    check("cf_lat", lat_obs, 32'd21);
    check("cf_rdata", rdata_obs, 32'hB000_0000);
    check("cf_miss", {16'd0, miss_cnt}, 32'd2);

    // Refill with a gap after every beat
    f0 = fill_cnt;
    do_read(32'h0000_5AB7, 32'hC000_0000, 1'b1, -1, 1'b0);
    check("gap_maddr", {4'd0, maddr_obs}, 32'h0000_05AB);
    check("gap_lat", lat_obs, 32'd36);
    check("gap_rdata", rdata_obs, 32'hC000_0007);
    check("gap_fills", fill_cnt - f0, 32'd1);
    for (int w = 0; w < 16; w++) check("gap_word", fill_line[w*32 +: 32], 32'hC000_0000 + w);
    do_read(32'h0000_5ABF, 32'h0, 1'b0, -1, 1'b0);
    check("gap_hit_lat", lat_obs, 32'd3);
    check("gap_hit_rdata", rdata_obs, 32'hC000_000F);
    check("gap_hit_cnt", {16'd0, hit_cnt}, 32'd3);
    check("gap_miss_cnt", {16'd0, miss_cnt}, 32'd3);

    // Reset at beat 7 of a refill
    @(negedge clk);
    f0 = fill_cnt;
    r0 = rv_cnt;
    do_read(32'h0000_7770, 32'hE000_0000, 1'b0, 7, 1'b0);
    check("ab_mem_req", {31'd0, mem_req}, 32'd0);
    check("ab_c_mode", {31'd0, c_mode}, 32'd0);
    check("ab_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("ab_ready", {31'd0, cpu_ready}, 32'd1);
    check("ab_miss", {16'd0, miss_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    check("ab_fills", fill_cnt - f0, 32'd0);
    check("ab_rvalids", rv_cnt - r0, 32'd0);
    do_read(32'h0000_7775, 32'hD000_0000, 1'b0, -1, 1'b0);
    check("ab_next_maddr", {4'd0, maddr_obs}, 32'h0000_0777);
    check("ab_next_lat", lat_obs, 32'd21);
    check("ab_next_rdata", rdata_obs, 32'hD000_0005);
    check("ab_next_miss", {16'd0, miss_cnt}, 32'd1);
    do_read(32'h0000_5ABF, 32'h0, 1'b0, -1, 1'b0);
    check("keep_lat", lat_obs, 32'd3);
    check("keep_rdata", rdata_obs, 32'hC000_000F);
    check("keep_hit", {16'd0, hit_cnt}, 32'd1);

    // cpu_req held high across back-to-back hits with hit_cnt near saturation
    @(negedge clk);
    r0  = rv_cnt;
    acc = 0;
    dut.hit_cnt_q = 16'hFFFE;
    cpu_addr = 32'h0000_5AB7;
    cpu_req  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cpu_ready) acc++;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_accepts", acc, 32'd3);
    check("b2b_rvalids", rv_cnt - r0, 32'd3);
    check("b2b_rdata", cpu_rdata, 32'hC000_0007);
    check("sat_hit", {16'd0, hit_cnt}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
